// File: rtl/ram_burst_controller.sv
// Burst sequencer for a small single-port asynchronous RAM: one write or read
// burst per command, sequential wrapping addresses, registered RAM pins.
module ram_burst_controller #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W-1:0] cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   count_reg, count_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic                ram_we_reg, ram_we_next;
    logic [ADDR_W-1:0]   ram_addr_reg, ram_addr_next;
    logic [DATA_W-1:0]   ram_din_reg, ram_din_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            count_reg    <= '0;
            addr_reg     <= '0;
            ram_we_reg   <= 1'b0;
            ram_addr_reg <= '0;
            ram_din_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            count_reg    <= count_next;
            addr_reg     <= addr_next;
            ram_we_reg   <= ram_we_next;
            ram_addr_reg <= ram_addr_next;
            ram_din_reg  <= ram_din_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        count_next    = count_reg;
        addr_next     = addr_reg;
        ram_we_next   = 1'b0;
        ram_addr_next = ram_addr_reg;
        ram_din_next  = ram_din_reg;
        cmd_ready     = 1'b0;
        wr_ready      = 1'b0;
        rd_valid      = 1'b0;
        done          = 1'b0;
        busy          = 1'b1;

        case (state_reg)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    count_next = cmd_len;
                    addr_next  = cmd_addr;
                    if (cmd_write) begin
                        state_next = WRITE;
                    end else begin
                        // Present the first read address right away so
                        // rd_data is valid in the very next cycle.
                        state_next    = READ;
                        ram_addr_next = cmd_addr;
                    end
                end
            end
            WRITE: begin
                wr_ready = 1'b1;
                if (wr_valid) begin
                    ram_we_next   = 1'b1;
                    ram_addr_next = addr_reg;
                    ram_din_next  = wr_data;
                    addr_next     = addr_reg + ONE;
                    count_next    = count_reg - ONE;
                    if (count_reg == '0) begin
                        state_next = DONE;
                    end
                end
            end
            READ: begin
                rd_valid = 1'b1;
                if (rd_ready) begin
                    ram_addr_next = ram_addr_reg + ONE;
                    count_next    = count_reg - ONE;
                    if (count_reg == '0) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign ram_we   = ram_we_reg;
    assign ram_addr = ram_addr_reg;
    assign ram_din  = ram_din_reg;
    assign rd_data  = ram_dout;

endmodule

// File: tb/tb_ram_burst_controller.sv
// Directed + randomized bench for ram_burst_controller with a behavioural RAM
// and an expected-memory reference model.
module tb_ram_burst_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid, cmd_ready, cmd_write;
    logic [3:0] cmd_addr, cmd_len;
    logic       wr_valid, wr_ready;
    logic [7:0] wr_data;
    logic       rd_valid, rd_ready;
    logic [7:0] rd_data;
    logic       ram_we;
    logic [3:0] ram_addr;
    logic [7:0] ram_din, ram_dout;
    logic       busy, done;

    int n_cmp = 0;
    int n_fail = 0;
    int done_cnt = 0;

    logic [7:0]  mem [16];
    logic [7:0]  ref_mem [16];
    logic [7:0]  wbuf [16];
    logic [11:0] wq [$];

    always #5 clk = ~clk;

    ram_burst_controller dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
        .busy(busy), .done(done)
    );

    // 16x8 RAM: stable addr/din for the whole we cycle, so committing at the edge is equivalent
    always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_din;
    assign ram_dout = mem[ram_addr];

    always @(negedge clk) begin
        if (ram_we) wq.push_back({ram_addr, ram_din});
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue_cmd(input logic wr, input logic [3:0] a, input logic [3:0] l);
        int t = 0;
        while (!cmd_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = l;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom); cmd_addr = 4'($urandom); cmd_len = 4'($urandom);
        check("busy_after_cmd", busy, 1);
        check("cmd_ready_busy", cmd_ready, 0);
    endtask

    task automatic do_write(input logic [3:0] a, input logic [3:0] l, input int stall_pct, input bit poke);
        int beats = int'(l) + 1;
        int i = 0;
        int cyc = 0;
        int d0;
        logic [3:0] ea;
        wq.delete();
        d0 = done_cnt;
        issue_cmd(1'b1, a, l);
        while (i < beats && cyc < 200) begin
            check("wr_ready", wr_ready, 1);
            if (poke) begin
                cmd_valid = 1'($urandom_range(0, 1));
                check("cmd_ready_in_write", cmd_ready, 0);
            end
            if (int'($urandom_range(0, 99)) < stall_pct) begin
                wr_valid = 1'b0;
                wr_data  = 8'($urandom);
            end else begin
                wr_valid = 1'b1;
                wr_data  = wbuf[i];
            end
            @(negedge clk);
            if (wr_valid) begin
                ref_mem[(int'(a) + i) % 16] = wbuf[i];
                i++;
            end
            cyc++;
        end
        wr_valid  = 1'b0;
        cmd_valid = 1'b0;
        check("wr_beats_accepted", i, beats);
        ea = 4'((int'(a) + int'(l)) % 16);
        check("done_pulse", done, 1);
        check("busy_in_done", busy, 1);
        check("cmd_ready_in_done", cmd_ready, 0);
        check("wr_ready_in_done", wr_ready, 0);
        check("last_we_in_done", ram_we, 1);
        check("last_addr_in_done", ram_addr, ea);
        check("last_din_in_done", ram_din, wbuf[l]);
        @(negedge clk);
        check("done_cleared", done, 0);
        check("idle_busy", busy, 0);
        check("idle_cmd_ready", cmd_ready, 1);
        check("wr_log_len", wq.size(), beats);
        for (int j = 0; j < beats && j < wq.size(); j++) begin
            ea = 4'((int'(a) + j) % 16);
            check("wr_log", wq[j], {ea, wbuf[j]});
        end
        if (poke) begin
            repeat (3) begin
                @(negedge clk);
                check("no_extra_burst", busy, 0);
            end
        end
        check("done_count", done_cnt - d0, 1);
    endtask

    task automatic do_read(input logic [3:0] a, input logic [3:0] l, input int mode);
        int beats = int'(l) + 1;
        int i = 0;
        int k = 0;
        int d0 = done_cnt;
        issue_cmd(1'b0, a, l);
        while (i < beats && k < 200) begin
            check("rd_valid", rd_valid, 1);
            check("rd_data", rd_data, ref_mem[(int'(a) + i) % 16]);
            check("rd_no_we", ram_we, 0);
            case (mode)
                0:       rd_ready = 1'b1;
                1:       rd_ready = (k % 4 == 0) || (k % 4 == 3);
                default: rd_ready = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            if (rd_ready) i++;
            k++;
        end
        rd_ready = 1'b0;
        check("rd_beats_taken", i, beats);
        check("rd_done_pulse", done, 1);
        check("rd_valid_in_done", rd_valid, 0);
        @(negedge clk);
        check("rd_idle_busy", busy, 0);
        check("rd_done_count", done_cnt - d0, 1);
    endtask

    initial begin
        int d0;
        logic [3:0] ra, rl;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ram_din", ram_din, 0);
        check("rst_wr_ready", wr_ready, 0);
        check("rst_rd_valid", rd_valid, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Two-beat write/read
        wbuf[0] = 8'hAA; wbuf[1] = 8'h55;
        do_write(4'd2, 4'd1, 0, 1'b0);
        do_read(4'd2, 4'd1, 0);

        // Wrap-around
        wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33;
        do_write(4'd14, 4'd2, 0, 1'b0);
        do_read(4'd14, 4'd2, 0);

        // Full 16-beat burst
        for (int i = 0; i < 16; i++) wbuf[i] = 8'(i * 3);
        do_write(4'd0, 4'd15, 0, 1'b0);
        do_read(4'd0, 4'd15, 0);

        // Read backpressure and write stalls
        do_read(4'd6, 4'd3, 1);
        for (int i = 0; i < 16; i++) wbuf[i] = 8'($urandom);
        do_write(4'd9, 4'd5, 40, 1'b0);
        do_read(4'd9, 4'd5, 1);

        // Command pokes while a write is running
        for (int i = 0; i < 16; i++) wbuf[i] = 8'($urandom);
        do_write(4'd5, 4'd3, 20, 1'b1);
        do_read(4'd5, 4'd3, 0);

        // Randomized bursts
        for (int n = 0; n < 6; n++) begin
            ra = 4'($urandom_range(0, 15));
            rl = 4'($urandom_range(0, 15));
            for (int i = 0; i < 16; i++) wbuf[i] = 8'($urandom);
            do_write(ra, rl, 30, 1'b0);
            do_read(ra, rl, 2);
        end

        // Reset after two beats of a five-beat write
        for (int i = 0; i < 16; i++) wbuf[i] = 8'($urandom);
        ra = 4'd12;
        wq.delete();
        d0 = done_cnt;
        issue_cmd(1'b1, ra, 4'd4);
        wr_valid = 1'b1; wr_data = wbuf[0];
        @(negedge clk);
        wr_data = wbuf[1];
        @(negedge clk);
        wr_valid = 1'b0;
        ref_mem[12] = wbuf[0];
        ref_mem[13] = wbuf[1];
        check("pre_rst_we", ram_we, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_ram_we", ram_we, 0);
        check("midrst_ram_addr", ram_addr, 0);
        check("midrst_ram_din", ram_din, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_cmd_ready", cmd_ready, 1);
        check("midrst_wr_ready", wr_ready, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_no_done", done_cnt - d0, 0);
        check("midrst_wr_log", wq.size(), 2);
        do_read(ra, 4'd1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_burst_controller.md
# ram_burst_controller

Burst sequencer that sits directly upstream of the 16x8 single-port asynchronous RAM. It accepts one write or read command at a time over a valid/ready handshake and streams data in from a write channel or out to a read channel. It drives the RAM's we/addr/din pins from registers and consumes the RAM's combinational dout. Addresses increment sequentially and wrap modulo the RAM depth.

## Interface
- ADDR_W, 4, RAM address width; depth = 2^ADDR_W
- DATA_W, 8, data width
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller can take a command (high only in IDLE)
- cmd_write  in  1  1 = write burst, 0 = read burst
- cmd_addr  in  ADDR_W  start address
- cmd_len  in  ADDR_W  burst length minus one (0 → 1 beat, 15 → 16 beats)
- wr_valid  in  1  write beat present
- wr_ready  out  1  write beat accepted this cycle if wr_valid
- wr_data  in  DATA_W  write beat data
- rd_valid  out  1  read beat present
- rd_ready  in  1  consumer takes read beat
- rd_data  out  DATA_W  read beat data (= ram_dout)
- ram_we  out  1  RAM write enable, registered
- ram_addr  out  ADDR_W  RAM address, registered
- ram_din  out  DATA_W  RAM write data, registered
- ram_dout  in  DATA_W  RAM asynchronous read data
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at burst completion

## Operation
- States: IDLE, WRITE, READ, DONE.
- IDLE: cmd_ready=1. On cmd_valid: latch remaining count ← cmd_len, next address ← cmd_addr, go to WRITE (cmd_write=1) or READ (cmd_write=0). For a read command, ram_addr ← cmd_addr on the same edge.
- WRITE: wr_ready=1. Each beat with wr_valid=1 is accepted. On the next edge: ram_we←1, ram_addr←beat address, ram_din←wr_data. The beat address then increments and the remaining count decrements. A cycle with wr_valid=0 writes nothing: ram_we←0 on the next edge. Acceptance of the last beat (remaining count = 0) moves the state to DONE.
- READ: rd_valid=1, rd_data=ram_dout (combinational from the registered ram_addr). When rd_ready=1: ram_addr increments and the remaining count decrements. When the last beat is taken, go to DONE. ram_we stays 0.
- DONE: done=1 and busy=1 for exactly one cycle, then IDLE. cmd_ready=0 in this cycle.
- Address arithmetic is ADDR_W-bit unsigned and wraps 2^ADDR_W−1 → 0. The remaining count is ADDR_W bits.
- Commands are never queued. cmd_valid outside IDLE has no effect.
- wr_ready=0 outside WRITE. rd_valid=0 outside READ.

## Timing
- Reset (rst_n=0 at a rising edge): state=IDLE, ram_we=0, ram_addr=0, ram_din=0, done=0, busy=0. rd_valid=0, wr_ready=0, cmd_ready=1 after the edge.
- Reset mid-burst aborts the burst. The in-flight ram_we drops at the reset edge. Beats already written stay in the RAM. No done pulse.
- Write latency: a beat accepted at edge N appears on ram_we/addr/din during cycle N..N+1. The final beat's write is active during the DONE cycle.
- Write throughput: 1 beat/cycle.
- Read latency: first rd_valid in the cycle after command acceptance. Throughput is 1 beat/cycle with rd_ready held high.
- ram_addr and ram_din are stable for the whole cycle while ram_we=1. They change only at clock edges.
- Command-to-IDLE: an N-beat burst without stalls takes N+1 cycles in non-IDLE states (N beat cycles + DONE).

## Test plan
- Write then read, 2 beats: write cmd addr=2, len=1, data AA,55. Required: ram_we pulses at addr 2 (din AA) then addr 3 (din 55), then done. Read cmd addr=2, len=1 returns AA, 55.
- Wrap-around: write addr=14, len=2, data 11,22,33. Required: writes land at 14, 15, 0. Read addr=14, len=2 returns 11,22,33.
- Full 16-beat burst: write addr=0, len=15, data i*3. Required: read back matches at every address, and done asserts exactly once per burst.
- Read backpressure: toggle rd_ready 1,0,0,1,… on a 4-beat read. Required: rd_data holds while rd_ready=0 and the beat order is unchanged. Write stall: gaps in wr_valid produce ram_we=0 cycles and skip no address.
- Command while busy: pulse cmd_valid during a write burst. Required: cmd_ready=0, and the current burst is unaffected with no extra burst.
- Reset mid-write: assert rst_n=0 after 2 beats of a 5-beat write. Required: ram_we=0 and all outputs at reset values next cycle, state IDLE, no done, and the first 2 addresses hold the written data.
